// File: rtl/skid_pipe_reg.sv
// ============================================================================
// Module   : skid_pipe_reg
// Purpose  : Two-entry skid-buffered pipeline stage with valid/ready on both
//            sides, registered upstream ready and synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_pipe_reg #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic [WIDTH-1:0] skid_q,  skid_d;

    logic w_main_valid;
    logic w_skid_valid;
    logic w_accept;
    logic w_emit;

    // Valid bits are the occupancy state itself, so they can never disagree.
    assign w_main_valid = (state_q == S_ONE) || (state_q == S_FULL);
    assign w_skid_valid = (state_q == S_FULL);

    assign out_valid = w_main_valid;
    assign in_ready  = ~w_skid_valid;
    assign out_data  = main_q;
    assign count     = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

    assign w_accept = in_valid & in_ready;
    assign w_emit   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            S_EMPTY: begin
                if (w_accept) begin
                    main_d  = in_data;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (w_accept && w_emit) begin
                    main_d = in_data;
                end else if (w_accept) begin
                    skid_d  = in_data;
                    state_d = S_FULL;
                end else if (w_emit) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_emit) begin
                    main_d  = skid_q;
                    state_d = S_ONE;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase

        // Flush squashes everything, including a word accepted this cycle.
        if (flush) begin
            state_d = S_EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_skid_pipe_reg.sv
// ============================================================================
// Module   : tb_skid_pipe_reg
// Purpose  : Directed and random-backpressure checks of skid_pipe_reg against
//            a queue model of the stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_skid_pipe_reg;

    localparam int unsigned      C_WIDTH = 8;
    localparam logic [7:0]       C_RST   = 8'h5A;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [C_WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [C_WIDTH-1:0] out_data;
    logic [1:0]       count;

    int n_cmp  = 0;
    int n_fail = 0;

    skid_pipe_reg #(.WIDTH(C_WIDTH), .RESET_VAL(C_RST)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO of at most two words; out_data shows the last head (held when empty).
    logic [7:0] mq[$];
    logic [7:0] m_head = C_RST;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_head = C_RST;
        end else begin
            bit acc, emt;
            acc = in_valid && (mq.size() < 2);
            emt = (mq.size() > 0) && out_ready;
            if (flush) begin
                mq.delete();
                m_head = C_RST;
            end else begin
                if (emt) void'(mq.pop_front());
                if (acc) mq.push_back(in_data);
                if (mq.size() > 0) m_head = mq[0];
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid", int'(out_valid), int'(mq.size() > 0));
        chk("in_ready",  int'(in_ready),  int'(mq.size() < 2));
        chk("count",     int'(count),     mq.size());
        chk("out_data",  int'(out_data),  int'(m_head));
        if (count == 2'd3) chk("count_not_3", int'(count), 2);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset then stream
        rst = 1'b0; out_ready = 1'b1;
        cyc(); cyc();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready",  int'(in_ready),  1);
        chk("rst_count",     int'(count),     0);
        chk("rst_out_data",  int'(out_data),  'h5A);
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            cyc();
            chk("stream_valid", int'(out_valid), 1);
            chk("stream_data",  int'(out_data),  i);
            chk("stream_count", int'(count),     1);
            chk("stream_ready", int'(in_ready),  1);
        end
        in_valid = 1'b0;
        cyc();
        chk("drain_valid", int'(out_valid), 0);
        chk("held_data",   int'(out_data),  4);

        // Stall fill
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h0A; cyc();
        chk("fill1_count", int'(count), 1);
        in_data = 8'h0B; cyc();
        chk("fill2_count", int'(count),    2);
        chk("fill2_ready", int'(in_ready), 0);
        in_data = 8'h0C; cyc();
        chk("fill3_count", int'(count),    2);
        chk("fill3_data",  int'(out_data), 'h0A);
        in_valid = 1'b0;
        out_ready = 1'b1; #1;
        chk("ready_no_comb_path", int'(in_ready), 0);
        out_ready = 1'b0; #1;

        // Drain after stall
        out_ready = 1'b1;
        cyc();
        chk("drain1_data",  int'(out_data), 'h0B);
        chk("drain1_count", int'(count),    1);
        chk("drain1_ready", int'(in_ready), 1);
        cyc();
        chk("drain2_valid", int'(out_valid), 0);
        chk("drain2_count", int'(count),     0);
        cyc();
        chk("drain3_count", int'(count), 0);

        // Flush beats simultaneous accept
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h05; cyc();
        chk("pre_flush_data", int'(out_data), 5);
        in_data = 8'h06; flush = 1'b1; cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", int'(count),     0);
        chk("flush_valid", int'(out_valid), 0);
        chk("flush_data",  int'(out_data),  'h5A);
        cyc();
        chk("flush_no6", int'(out_valid), 0);

        // Async reset mid-operation
        in_valid = 1'b1; in_data = 8'h11; cyc();
        in_data = 8'h22; cyc();
        in_valid = 1'b0;
        chk("prerst_count", int'(count), 2);
        #2 rst = 1'b0; #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_ready", int'(in_ready),  1);
        chk("arst_count", int'(count),     0);
        chk("arst_data",  int'(out_data),  'h5A);
        cyc();
        rst = 1'b1;
        in_valid = 1'b1; in_data = 8'h07; cyc();
        in_valid = 1'b0;
        chk("post_rst_data",  int'(out_data),  7);
        chk("post_rst_valid", int'(out_valid), 1);
        out_ready = 1'b1; cyc();

        // Random back-pressure
        for (int i = 0; i < 1000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc(); cyc(); cyc();
        chk("final_empty", int'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
